pong_game_sequencer: RTL and testbench

Frame-synchronous game controller for the Pong datapath. It watches the composite ball and paddle video against the VGA blanking and reset strobes, and classifies each frame's ball contacts as paddle hit, wall bounce or miss. It then drives the ball direction bits and the ball-motion enable for the next frame. It also sequences serve / play / miss-pause / game-over and keeps the miss score. It replaces the switch-driven direction control between the Vga block and the Ball_Horizontal / Ball_Vertical pair.

---
 rtl/pong_game_sequencer_pkg.sv | 27 ++
 rtl/pong_game_sequencer_ball_contact_detect.sv | 77 +++++++
 rtl/pong_game_sequencer.sv | 135 +++++++++++++
 tb/tb_pong_game_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_game_sequencer_pkg.sv
// Shared definitions for the Pong game sequencer: state encodings, default
// game parameters and the per-frame contact flag bundle.
package pong_game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    localparam int DEF_MISS_FRAMES = 60;
    localparam int DEF_MAX_MISSES  = 9;

    typedef struct packed {
        logic paddle;
        logic left;
        logic right;
        logic top;
        logic bottom;
    } contact_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_sequencer_ball_contact_detect.sv
// Per-frame ball contact flags (paddle, four screen edges) derived from the
// composite video and the Vga blanking/reset strobes; cleared on each i_VReset.
module ball_contact_detect
    import pong_game_sequencer_pkg::*;
(
    input  logic     i_Clk,
    input  logic     i_Reset,
    input  logic     i_HReset,
    input  logic     i_VReset,
    input  logic     i_HBlank,
    input  logic     i_VBlank,
    input  logic     i_Ball_Video,
    input  logic     i_Paddle_Video,
    output contact_t o_Flags
);

    logic     hblank_q, vblank_q, ball_q;
    logic     first_line_q, first_line_d;
    logic     line_seen_q, line_seen_d;
    contact_t flags_q, flags_d, hit;
    logic     ball_act, hblank_fall, hblank_rise, vblank_fall, vblank_rise;

    always_comb begin
        ball_act    = i_Ball_Video & ~i_HBlank & ~i_VBlank;
        hblank_fall = hblank_q & ~i_HBlank;
        hblank_rise = i_HBlank & ~hblank_q;
        vblank_fall = vblank_q & ~i_VBlank;
        vblank_rise = i_VBlank & ~vblank_q;

        hit        = '0;
        hit.paddle = ball_act & i_Paddle_Video;
        hit.left   = ball_act & hblank_fall;
        // ball_q holds the last active pixel of the line when HBlank rises
        hit.right  = hblank_rise & ball_q;
        // first_line_q is still set on the next line's HReset cycle, so mask it
        hit.top    = ball_act & (vblank_fall | (first_line_q & ~i_HReset));
        hit.bottom = vblank_rise & line_seen_q;

        first_line_d = first_line_q;
        if (vblank_fall) begin
            first_line_d = 1'b1;
        end else if (i_HReset) begin
            first_line_d = 1'b0;
        end

        // Restart at each active line's first pixel; held through blanking so
        // the VBlank rise sees the last active line.
        if (hblank_fall & ~i_VBlank) begin
            line_seen_d = ball_act;
        end else begin
            line_seen_d = line_seen_q | ball_act;
        end

        flags_d = i_VReset ? hit : (flags_q | hit);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            ball_q       <= 1'b0;
            first_line_q <= 1'b0;
            line_seen_q  <= 1'b0;
            flags_q      <= '0;
        end else begin
            hblank_q     <= i_HBlank;
            vblank_q     <= i_VBlank;
            ball_q       <= ball_act;
            first_line_q <= first_line_d;
            line_seen_q  <= line_seen_d;
            flags_q      <= flags_d;
        end
    end

    assign o_Flags = flags_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Frame-synchronous Pong controller: turns per-frame ball contacts into ball
// directions and motion enable, and sequences serve/play/miss/game-over.
module pong_game_sequencer
    import pong_game_sequencer_pkg::*;
#(
    parameter int p_MISS_FRAMES = DEF_MISS_FRAMES,
    parameter int p_MAX_MISSES  = DEF_MAX_MISSES
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_HReset,
    input  logic       i_VReset,
    input  logic       i_HBlank,
    input  logic       i_VBlank,
    input  logic       i_Ball_Video,
    input  logic       i_Paddle_Video,
    input  logic       i_Serve,
    output logic       o_HDir,
    output logic       o_VDir,
    output logic       o_Ball_Enable,
    output logic [3:0] o_Score,
    output logic [1:0] o_State,
    output logic       o_Game_Over
);

    localparam int            CW        = (p_MISS_FRAMES > 1) ? $clog2(p_MISS_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(p_MISS_FRAMES - 1);
    localparam logic [3:0]    MAX_SCORE = 4'(p_MAX_MISSES);

    state_e        state_q, state_d;
    logic [3:0]    score_q, score_d, score_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hdir_q, hdir_d, vdir_q, vdir_d, en_q, en_d;
    logic          serve_q, serve_rise, miss;
    contact_t      flags;

    ball_contact_detect u_contact (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_HReset       (i_HReset),
        .i_VReset       (i_VReset),
        .i_HBlank       (i_HBlank),
        .i_VBlank       (i_VBlank),
        .i_Ball_Video   (i_Ball_Video),
        .i_Paddle_Video (i_Paddle_Video),
        .o_Flags        (flags)
    );

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
        hdir_d     = hdir_q;
        vdir_d     = vdir_q;
        en_d       = en_q;
        serve_rise = i_Serve & ~serve_q;
        miss       = flags.left & ~flags.paddle;
        score_inc  = sat_inc4(score_q);

        case (state_q)
            ST_IDLE: begin
                hdir_d = 1'b1;
                vdir_d = 1'b1;
                if (serve_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (i_VReset) begin
                    if (flags.top & ~flags.bottom) begin
                        vdir_d = 1'b1;
                    end else if (flags.bottom & ~flags.top) begin
                        vdir_d = 1'b0;
                    end
                    // A paddle contact always wins over a left-edge miss
                    if (flags.paddle) begin
                        hdir_d = 1'b1;
                    end else if (miss) begin
                        hdir_d  = 1'b1;
                        score_d = score_inc;
                        cnt_d   = CNT_LOAD;
                        state_d = (score_inc == MAX_SCORE) ? ST_OVER : ST_MISS;
                    end else if (flags.right) begin
                        hdir_d = 1'b0;
                    end
                end
            end
            ST_MISS: begin
                if (i_VReset) begin
                    if (cnt_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (serve_rise) begin
                    score_d = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Motion enable only moves at frame boundaries so the ball never moves part-frame
        if (i_VReset) en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            score_q <= 4'd0;
            cnt_q   <= '0;
            hdir_q  <= 1'b1;
            vdir_q  <= 1'b1;
            en_q    <= 1'b0;
            serve_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            hdir_q  <= hdir_d;
            vdir_q  <= vdir_d;
            en_q    <= en_d;
            serve_q <= i_Serve;
        end
    end

    assign o_HDir        = hdir_q;
    assign o_VDir        = vdir_q;
    assign o_Ball_Enable = en_q;
    assign o_Score       = score_q;
    assign o_State       = state_q;
    assign o_Game_Over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Self-checking bench for pong_game_sequencer: a small raster generator drives
// rectangular balls, a game-rule model predicts the outputs after every frame.
module tb_pong_game_sequencer;

    localparam int H_ACT = 8;
    localparam int H_TOT = 10;
    localparam int V_ACT = 6;
    localparam int V_TOT = 7;
    localparam int FRAME_PX = H_TOT * V_TOT;
    localparam int MISS_FRAMES = 60;
    localparam int MAX_MISSES = 9;

    typedef struct {
        bit has;
        int x0, x1, y0, y1;
        bit paddle;
    } frame_t;

    logic       clk = 1'b0;
    logic       i_Reset, i_HReset, i_VReset, i_HBlank, i_VBlank;
    logic       i_Ball_Video, i_Paddle_Video, i_Serve;
    logic       o_HDir, o_VDir, o_Ball_Enable, o_Game_Over;
    logic [3:0] o_Score;
    logic [1:0] o_State;

    logic [9:0] exp_q[$];
    int total = 0;
    int bad = 0;

    // reference game model
    int m_state, m_score, m_wait;
    bit m_hdir, m_vdir, m_en;

    pong_game_sequencer dut (
        .i_Clk          (clk),
        .i_Reset        (i_Reset),
        .i_HReset       (i_HReset),
        .i_VReset       (i_VReset),
        .i_HBlank       (i_HBlank),
        .i_VBlank       (i_VBlank),
        .i_Ball_Video   (i_Ball_Video),
        .i_Paddle_Video (i_Paddle_Video),
        .i_Serve        (i_Serve),
        .o_HDir         (o_HDir),
        .o_VDir         (o_VDir),
        .o_Ball_Enable  (o_Ball_Enable),
        .o_Score        (o_Score),
        .o_State        (o_State),
        .o_Game_Over    (o_Game_Over)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [9:0] pack(input int st, input bit en, input bit h, input bit v,
                                        input int sc, input bit go);
        return {st[1:0], en, h, v, sc[3:0], go};
    endfunction

    function automatic logic [9:0] dut_pack();
        return {o_State, o_Ball_Enable, o_HDir, o_VDir, o_Score, o_Game_Over};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (state,en,hdir,vdir,score,over)", name, got, exp);
        end
    endtask

    function automatic frame_t blank_frame();
        frame_t f;
        f.has = 0; f.x0 = 0; f.x1 = 0; f.y0 = 0; f.y1 = 0; f.paddle = 0;
        return f;
    endfunction

    function automatic frame_t ball_frame(input int x0, input int x1, input int y0, input int y1,
                                          input bit pad);
        frame_t f;
        f.has = 1; f.x0 = x0; f.x1 = x1; f.y0 = y0; f.y1 = y1; f.paddle = pad;
        return f;
    endfunction

    function automatic frame_t miss_frame();
        int y = $urandom_range(1, V_ACT - 2);
        return ball_frame(0, 0, y, y, 0);
    endfunction

    // Small random balls; never paddle together with a right-edge contact
    function automatic frame_t random_frame();
        int k = $urandom_range(0, 4);
        int x0, x1, y0, y1;
        if (k == 0) return blank_frame();
        if (k == 4) begin
            x0 = $urandom_range(1, H_ACT - 2);
            return ball_frame(x0, x0, 0, V_ACT - 1, 1'($urandom_range(0, 1)));
        end
        x0 = $urandom_range(0, H_ACT - 1);
        x1 = x0 + $urandom_range(0, 2);
        if (x1 > H_ACT - 1) x1 = H_ACT - 1;
        y0 = $urandom_range(0, V_ACT - 1);
        y1 = y0 + $urandom_range(0, 2);
        if (y1 > V_ACT - 1) y1 = V_ACT - 1;
        return ball_frame(x0, x1, y0, y1, (x1 != H_ACT - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_wait = 0;
        m_hdir = 1; m_vdir = 1; m_en = 0;
    endtask

    task automatic model_serve();
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 3) begin
            m_state = 0;
            m_score = 0;
        end
    endtask

    // Game rules applied at the frame boundary that follows frame f
    task automatic model_boundary(input frame_t f, input bit valid);
        bit top = 0, bot = 0, lft = 0, rgt = 0, pad = 0;
        if (valid && f.has) begin
            lft = (f.x0 == 0);
            rgt = (f.x1 == H_ACT - 1);
            top = (f.y0 == 0);
            bot = (f.y1 == V_ACT - 1);
            pad = f.paddle;
        end
        case (m_state)
            0: begin
                m_hdir = 1;
                m_vdir = 1;
            end
            1: begin
                if (top && !bot) m_vdir = 1;
                else if (bot && !top) m_vdir = 0;
                if (pad) begin
                    m_hdir = 1;
                end else if (lft) begin
                    m_hdir = 1;
                    m_score = (m_score < 15) ? m_score + 1 : 15;
                    if (m_score == MAX_MISSES) begin
                        m_state = 3;
                    end else begin
                        m_state = 2;
                        m_wait = MISS_FRAMES - 1;
                    end
                end else if (rgt) begin
                    m_hdir = 0;
                end
            end
            2: begin
                if (m_wait == 0) m_state = 1;
                else m_wait--;
            end
            default: ;
        endcase
        m_en = (m_state == 1);
        exp_q.push_back(pack(m_state, m_en, m_hdir, m_vdir, m_score, m_state == 3));
    endtask

    // Drives npx pixels of one frame; a full frame also predicts the next boundary
    task automatic run_frame(input frame_t f, input int serve_px, input int reset_px, input int npx);
        for (int px = 0; px < npx; px++) begin
            int h = px % H_TOT;
            int v = px / H_TOT;
            bit in_ball;
            @(negedge clk);
            if (serve_px >= 0 && px == serve_px + 1)
                check("serve_state", {8'd0, o_State}, {8'd0, 2'(m_state)});
            if (reset_px >= 0 && px == reset_px + 1)
                check("midframe_reset", dut_pack(), pack(0, 0, 1, 1, 0, 0));
            in_ball = f.has && h >= f.x0 && h <= f.x1 && v >= f.y0 && v <= f.y1
                      && h < H_ACT && v < V_ACT;
            i_HReset       = (h == 0);
            i_VReset       = (px == 0);
            i_HBlank       = (h >= H_ACT);
            i_VBlank       = (v >= V_ACT);
            i_Ball_Video   = in_ball;
            i_Paddle_Video = in_ball && f.paddle;
            i_Serve        = (px == serve_px);
            i_Reset        = (px == reset_px);
            if (px == serve_px) model_serve();
            if (px == reset_px) model_reset();
        end
        if (npx == FRAME_PX) model_boundary(f, reset_px < 0);
    endtask

    // Monitor: one registered output update per frame boundary
    initial begin
        forever begin
            @(posedge clk);
            if (i_VReset === 1'b1 && i_Reset === 1'b0) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_out got=%h exp=<none queued>", dut_pack());
                end else begin
                    check("frame_out", dut_pack(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        frame_t f;
        i_Reset = 1; i_HReset = 0; i_VReset = 0; i_HBlank = 1; i_VBlank = 1;
        i_Ball_Video = 0; i_Paddle_Video = 0; i_Serve = 0;
        repeat (4) @(negedge clk);
        check("reset_values", dut_pack(), pack(0, 0, 1, 1, 0, 0));
        i_Reset = 0;
        repeat (2) @(negedge clk);
        model_reset();
        model_boundary(blank_frame(), 0);

        // no serve: stays idle whatever the ball does
        for (int i = 0; i < 3; i++) run_frame(random_frame(), -1, -1, FRAME_PX);

        // serve, right-edge bounce, paddle+top, then a plain miss
        run_frame(blank_frame(), 35, -1, FRAME_PX);
        f = ball_frame(H_ACT - 1, H_ACT - 1, 2, 2, 0);
        run_frame(f, -1, -1, FRAME_PX);
        run_frame(ball_frame(0, 0, 0, 0, 1), -1, -1, FRAME_PX);
        run_frame(miss_frame(), -1, -1, FRAME_PX);

        // play on until the game ends; stray serves must be ignored
        for (int i = 0; i < 1500 && m_state != 3; i++) begin
            if (m_state == 1 && $urandom_range(0, 1) == 1) f = miss_frame();
            else f = random_frame();
            run_frame(f, ($urandom_range(0, 7) == 0) ? 35 : -1, -1, FRAME_PX);
        end

        // game over, then serve back to idle and start a new game
        run_frame(random_frame(), -1, -1, FRAME_PX);
        run_frame(random_frame(), 44, -1, FRAME_PX);
        run_frame(blank_frame(), -1, -1, FRAME_PX);
        run_frame(blank_frame(), 35, -1, FRAME_PX);
        for (int i = 0; i < 10 && m_state != 2; i++) run_frame(miss_frame(), -1, -1, FRAME_PX);

        // reset mid-line while the miss counter sits at 30
        for (int i = 0; i < 80 && m_state == 2 && m_wait != 30; i++)
            run_frame(random_frame(), -1, -1, FRAME_PX);
        run_frame(random_frame(), -1, 2 * H_TOT + 3, FRAME_PX);

        run_frame(blank_frame(), 35, -1, FRAME_PX);
        for (int i = 0; i < 6; i++) run_frame(random_frame(), -1, -1, FRAME_PX);
        run_frame(blank_frame(), -1, -1, FRAME_PX);
        run_frame(blank_frame(), -1, -1, 3);
        repeat (2) @(negedge clk);
        check("exp_q_drained", 10'(exp_q.size()), 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
